// File: rtl/pipeline_stall_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_pkg
// Shared definitions for the pipeline stall controller:
//   - state_e      : 2-bit controller state (RUN, LOAD_STALL, MEM_WAIT, FETCH_KILL)
//   - stage_ctrl_t : bundle of the five stage-register enables and two flushes
//   - CTRL_*       : canned enable/flush patterns, including the reset pattern
//   - LSF_BUBBLE   : value a load-to-store forward select takes inside a NOP bubble
//   - sat_inc()    : saturating increment used by the optional perf counters
// -----------------------------------------------------------------------------
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FETCH_KILL = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctrl_t;

    // Everything advances, nothing is squashed.
    localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // Whole pipe frozen while the data memory is busy.
    localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // While in reset nothing advances and both front registers hold bubbles.
    localparam stage_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // A bubble never carries a forward request.
    localparam logic LSF_BUBBLE = 1'b0;

    localparam int PERF_CNT_W = 32;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        return (value == {PERF_CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller_if
// Hazard/stall signalling between the pipeline and its stall controller.
//   master : the stall controller (consumes requests, drives enables/flushes)
//   slave  : the pipeline side (drives requests, consumes enables/flushes)
// Requests : load_use_stall_i, load_store_forward_sel_i, branch_taken_ex_i,
//            imem_ready_i, dmem_req_mem_i, dmem_ready_i
// Controls : pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
//            if_id_flush_o, id_ex_flush_o, lsf_sel_ex_o, lsf_sel_mem_o
// Optional : stall_cycles_o, flush_count_o exist only with STALL_PERF_CNT_EN.
// -----------------------------------------------------------------------------
interface pipeline_stall_controller_if;

    logic load_use_stall_i;
    logic load_store_forward_sel_i;
    logic branch_taken_ex_i;
    logic imem_ready_i;
    logic dmem_req_mem_i;
    logic dmem_ready_i;

    logic pc_en_o;
    logic if_id_en_o;
    logic id_ex_en_o;
    logic ex_mem_en_o;
    logic mem_wb_en_o;
    logic if_id_flush_o;
    logic id_ex_flush_o;
    logic lsf_sel_ex_o;
    logic lsf_sel_mem_o;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;

    modport master (
        input  load_use_stall_i, load_store_forward_sel_i, branch_taken_ex_i,
               imem_ready_i, dmem_req_mem_i, dmem_ready_i,
        output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o, lsf_sel_ex_o, lsf_sel_mem_o,
               stall_cycles_o, flush_count_o
    );

    modport slave (
        output load_use_stall_i, load_store_forward_sel_i, branch_taken_ex_i,
               imem_ready_i, dmem_req_mem_i, dmem_ready_i,
        input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o, lsf_sel_ex_o, lsf_sel_mem_o,
               stall_cycles_o, flush_count_o
    );
`else
    modport master (
        input  load_use_stall_i, load_store_forward_sel_i, branch_taken_ex_i,
               imem_ready_i, dmem_req_mem_i, dmem_ready_i,
        output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o, lsf_sel_ex_o, lsf_sel_mem_o
    );

    modport slave (
        output load_use_stall_i, load_store_forward_sel_i, branch_taken_ex_i,
               imem_ready_i, dmem_req_mem_i, dmem_ready_i,
        input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o, lsf_sel_ex_o, lsf_sel_mem_o
    );
`endif

endinterface

// File: rtl/pipeline_stall_controller_stall_perf_counter.sv
// -----------------------------------------------------------------------------
// stall_perf_counter
// Saturating 32-bit event counter used for stall/flush statistics.
// Only built when STALL_PERF_CNT_EN is defined.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, clears the count
//   inc_i   : count one event this cycle
//   count_o : current count, sticks at all-ones
// -----------------------------------------------------------------------------
`ifdef STALL_PERF_CNT_EN
module stall_perf_counter
    import pipeline_stall_controller_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inc_i,
    output logic [PERF_CNT_W-1:0] count_o
);

    logic [PERF_CNT_W-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (inc_i) begin
            count_reg <= sat_inc(count_reg);
        end
    end

    assign count_o = count_reg;

endmodule
`endif

// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
// Central stall/flush controller of a 5-stage in-order pipeline.
// Priority, highest first: data-memory freeze, branch flush, load-use stall,
// fetch stall. Enables and flushes are combinational (same-cycle) from the
// current state and the requests; only the state, the kill_pending flag and the
// two forward-select pipeline bits are registered.
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : pipeline_stall_controller_if.master (requests in, controls out)
// Optional feature: define STALL_PERF_CNT_EN to add stall_cycles_o and
// flush_count_o saturating counters (two stall_perf_counter instances).
// -----------------------------------------------------------------------------
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    pipeline_stall_controller_if.master   bus
);

    state_e      state_reg, state_next;
    logic        kill_pending_reg, kill_pending_next;
    logic        lsf_ex_reg, lsf_mem_reg;
    stage_ctrl_t ctrl_next;
    stage_ctrl_t ctrl;
    logic        freeze;
    logic        branch_flush;

    assign freeze = bus.dmem_req_mem_i & ~bus.dmem_ready_i;

    always_comb begin
        ctrl_next         = CTRL_RUN;
        state_next        = state_reg;
        kill_pending_next = kill_pending_reg;
        branch_flush      = 1'b0;

        if (freeze) begin
            ctrl_next = CTRL_FREEZE;
            // An outstanding fetch kill survives a freeze; otherwise wait in MEM_WAIT.
            state_next = (state_reg == FETCH_KILL) ? FETCH_KILL : MEM_WAIT;
        end else if (bus.branch_taken_ex_i) begin
            ctrl_next.if_id_flush = 1'b1;
            ctrl_next.id_ex_flush = 1'b1;
            branch_flush          = 1'b1;
            // A fetch still in flight belongs to the wrong path and must be
            // discarded when it finally returns.
            if (!bus.imem_ready_i) begin
                state_next        = FETCH_KILL;
                kill_pending_next = 1'b1;
            end else begin
                state_next        = RUN;
                kill_pending_next = 1'b0;
            end
        end else begin
            unique case (state_reg)
                MEM_WAIT: begin
                    // Release cycle of a freeze: the whole pipe advances.
                    state_next = RUN;
                end
                FETCH_KILL: begin
                    ctrl_next.pc_en = 1'b0;
                    if (bus.imem_ready_i) begin
                        // Wrong-path response arrives: squash it into IF/ID.
                        ctrl_next.if_id_flush = kill_pending_reg;
                        state_next            = RUN;
                        kill_pending_next     = 1'b0;
                    end else begin
                        // IF/ID already holds the branch bubble; keep it.
                        ctrl_next.if_id_en = 1'b0;
                    end
                end
                default: begin
                    // RUN and LOAD_STALL decode identically, so a load-use
                    // request still high in LOAD_STALL simply stalls again.
                    if (bus.load_use_stall_i) begin
                        ctrl_next.pc_en       = 1'b0;
                        ctrl_next.if_id_en    = 1'b0;
                        ctrl_next.id_ex_flush = 1'b1;
                        state_next            = LOAD_STALL;
                    end else if (!bus.imem_ready_i) begin
                        ctrl_next.pc_en       = 1'b0;
                        ctrl_next.if_id_flush = 1'b1;
                        state_next            = RUN;
                    end else begin
                        state_next = RUN;
                    end
                end
            endcase
        end
    end

    // Reset overrides the decode combinationally so the pipe is held with
    // bubbles for as long as rst_ni is low.
    assign ctrl = rst_ni ? ctrl_next : CTRL_RESET;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg        <= RUN;
            kill_pending_reg <= 1'b0;
            lsf_ex_reg       <= LSF_BUBBLE;
            lsf_mem_reg      <= LSF_BUBBLE;
        end else begin
            state_reg        <= state_next;
            kill_pending_reg <= kill_pending_next;
            // The forward select travels with its store: it is squashed with
            // the ID/EX bubble and holds whenever its stage register holds.
            if (ctrl.id_ex_flush) begin
                lsf_ex_reg <= LSF_BUBBLE;
            end else if (ctrl.id_ex_en) begin
                lsf_ex_reg <= bus.load_store_forward_sel_i;
            end
            if (ctrl.ex_mem_en) begin
                lsf_mem_reg <= lsf_ex_reg;
            end
        end
    end

    assign bus.pc_en_o       = ctrl.pc_en;
    assign bus.if_id_en_o    = ctrl.if_id_en;
    assign bus.id_ex_en_o    = ctrl.id_ex_en;
    assign bus.ex_mem_en_o   = ctrl.ex_mem_en;
    assign bus.mem_wb_en_o   = ctrl.mem_wb_en;
    assign bus.if_id_flush_o = ctrl.if_id_flush;
    assign bus.id_ex_flush_o = ctrl.id_ex_flush;
    assign bus.lsf_sel_ex_o  = lsf_ex_reg;
    assign bus.lsf_sel_mem_o = lsf_mem_reg;

`ifdef STALL_PERF_CNT_EN
    // Index 0: cycles with the PC held; index 1: branch flushes.
    logic [1:0]            perf_inc;
    logic [PERF_CNT_W-1:0] perf_count [2];

    assign perf_inc[0] = ~ctrl.pc_en;
    assign perf_inc[1] = branch_flush;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        stall_perf_counter u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (perf_inc[gi]),
            .count_o (perf_count[gi])
        );
    end

    assign bus.stall_cycles_o = perf_count[0];
    assign bus.flush_count_o  = perf_count[1];
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Table of {reset, requests, expected controls} rows driven one per cycle; each
// row's expectation is queued when driven and compared at the following
// negative clock edge. Extra hand sequences cover random-length freezes and,
// with STALL_PERF_CNT_EN, the perf counters.
// Input vector order   : {load_use, lsf_sel, branch, imem_ready, dmem_req, dmem_ready}
// Expected vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//                         if_id_flush, id_ex_flush, lsf_sel_ex, lsf_sel_mem}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_stall_controller;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    pipeline_stall_controller_if bus ();

    pipeline_stall_controller dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic       rstn;
        logic [5:0] in;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_item_t;

    vec_t     vecs [$];
    sb_item_t sb   [$];
    int       checks   = 0;
    int       failures = 0;

    localparam logic [5:0] IDLE     = 6'b000100;
    localparam logic [5:0] LU       = 6'b100100;
    localparam logic [5:0] LSF      = 6'b010100;
    localparam logic [5:0] LU_LSF   = 6'b110100;
    localparam logic [5:0] BR       = 6'b001100;
    localparam logic [5:0] BR_LU    = 6'b101100;
    localparam logic [5:0] IMEM0    = 6'b000000;
    localparam logic [5:0] BR_IMEM0 = 6'b001000;
    localparam logic [5:0] FRZ      = 6'b000110;
    localparam logic [5:0] FRZ_BR   = 6'b001110;
    localparam logic [5:0] RDY_BR   = 6'b001111;
    localparam logic [5:0] RDY_LU   = 6'b100111;
    localparam logic [5:0] RDY      = 6'b000111;

    localparam logic [8:0] E_RST    = 9'b00000_11_00;
    localparam logic [8:0] E_RUN    = 9'b11111_00_00;
    localparam logic [8:0] E_LU     = 9'b00111_01_00;
    localparam logic [8:0] E_BR     = 9'b11111_11_00;
    localparam logic [8:0] E_FETCH  = 9'b01111_10_00;
    localparam logic [8:0] E_KWAIT  = 9'b00111_00_00;
    localparam logic [8:0] E_FRZ    = 9'b00000_00_00;

    task automatic add_vec(input string n, input logic r, input logic [5:0] i, input logic [8:0] e);
        vec_t v;
        v.name = n;
        v.rstn = r;
        v.in   = i;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [5:0] i, input logic [8:0] e, input string n);
        sb_item_t it;
        @(posedge clk_i);
        #1;
        rst_ni = r;
        {bus.load_use_stall_i, bus.load_store_forward_sel_i, bus.branch_taken_ex_i,
         bus.imem_ready_i, bus.dmem_req_mem_i, bus.dmem_ready_i} = i;
        it.name = n;
        it.exp  = e;
        sb.push_back(it);
    endtask

    // Scoreboard: compare the oldest queued expectation mid-cycle.
    always @(negedge clk_i) begin
        if (sb.size() != 0) begin
            sb_item_t   it;
            logic [8:0] act;
            it  = sb.pop_front();
            act = {bus.pc_en_o, bus.if_id_en_o, bus.id_ex_en_o, bus.ex_mem_en_o,
                   bus.mem_wb_en_o, bus.if_id_flush_o, bus.id_ex_flush_o,
                   bus.lsf_sel_ex_o, bus.lsf_sel_mem_o};
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end else begin
                $display("ok   %s: %b", it.name, act);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        {bus.load_use_stall_i, bus.load_store_forward_sel_i, bus.branch_taken_ex_i,
         bus.imem_ready_i, bus.dmem_req_mem_i, bus.dmem_ready_i} = IDLE;

        add_vec("reset",            1'b0, IDLE,     E_RST);
        add_vec("idle",             1'b1, IDLE,     E_RUN);
        add_vec("lu_stall",         1'b1, LU,       E_LU);
        add_vec("lu_release",       1'b1, IDLE,     E_RUN);
        add_vec("lu_idle",          1'b1, IDLE,     E_RUN);
        add_vec("lu_again_1",       1'b1, LU,       E_LU);
        add_vec("lu_again_2",       1'b1, LU,       E_LU);
        add_vec("lu_again_rel",     1'b1, IDLE,     E_RUN);
        add_vec("lsf_no_stall",     1'b1, LSF,      E_RUN);
        add_vec("lsf_ex",           1'b1, IDLE,     9'b11111_00_10);
        add_vec("lsf_mem",          1'b1, IDLE,     9'b11111_00_01);
        add_vec("lsf_drain",        1'b1, IDLE,     E_RUN);
        add_vec("lsf_load",         1'b1, LSF,      E_RUN);
        add_vec("lsf_flush_lu",     1'b1, LU_LSF,   9'b00111_01_10);
        add_vec("lsf_after_flush",  1'b1, IDLE,     9'b11111_00_01);
        add_vec("lsf_pre_freeze",   1'b1, LSF,      E_RUN);
        add_vec("freeze_br_1",      1'b1, FRZ_BR,   9'b00000_00_10);
        add_vec("freeze_br_2",      1'b1, FRZ_BR,   9'b00000_00_10);
        add_vec("freeze_br_3",      1'b1, FRZ_BR,   9'b00000_00_10);
        add_vec("freeze_rdy_br",    1'b1, RDY_BR,   9'b11111_11_10);
        add_vec("post_freeze_1",    1'b1, IDLE,     9'b11111_00_01);
        add_vec("post_freeze_2",    1'b1, IDLE,     E_RUN);
        add_vec("br_plus_lu",       1'b1, BR_LU,    E_BR);
        add_vec("br_plus_lu_after", 1'b1, IDLE,     E_RUN);
        add_vec("fetch_stall",      1'b1, IMEM0,    E_FETCH);
        add_vec("fetch_resume",     1'b1, IDLE,     E_RUN);
        add_vec("kill_branch",      1'b1, BR_IMEM0, E_BR);
        add_vec("kill_wait",        1'b1, IMEM0,    E_KWAIT);
        add_vec("kill_return",      1'b1, IDLE,     E_FETCH);
        add_vec("kill_done",        1'b1, IDLE,     E_RUN);
        add_vec("rst_mid_lu",       1'b1, LU,       E_LU);
        add_vec("rst_mid_lu_rst",   1'b0, IDLE,     E_RST);
        add_vec("rst_mid_lu_after", 1'b1, IDLE,     E_RUN);
        add_vec("rst_mid_kill",     1'b1, BR_IMEM0, E_BR);
        add_vec("rst_mid_kill_rst", 1'b0, IDLE,     E_RST);
        add_vec("rst_kill_no_flush",1'b1, IDLE,     E_RUN);
        add_vec("rst_mid_frz",      1'b1, FRZ,      E_FRZ);
        add_vec("rst_mid_frz_rst",  1'b0, IDLE,     E_RST);
        add_vec("rst_frz_after",    1'b1, IDLE,     E_RUN);
        add_vec("rst_lsf_load",     1'b1, LSF,      E_RUN);
        add_vec("rst_lsf_clear",    1'b0, IDLE,     E_RST);
        add_vec("rst_lsf_after",    1'b1, IDLE,     E_RUN);
        add_vec("memwait_enter",    1'b1, FRZ,      E_FRZ);
        add_vec("memwait_exit_lu",  1'b1, RDY_LU,   E_RUN);
        add_vec("memwait_done",     1'b1, IDLE,     E_RUN);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rstn, vecs[i].in, vecs[i].exp, vecs[i].name);
        end

        // Random-length freezes, each released by a ready cycle.
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int c = 0; c < n; c++) begin
                step(1'b1, FRZ, E_FRZ, $sformatf("rand_freeze_%0d_%0d", k, c));
            end
            step(1'b1, RDY, E_RUN, $sformatf("rand_release_%0d", k));
        end

`ifdef STALL_PERF_CNT_EN
        step(1'b0, IDLE, E_RST, "perf_reset");
        for (int c = 0; c < 5; c++) begin
            step(1'b1, LU, E_LU, $sformatf("perf_stall_%0d", c));
        end
        step(1'b1, IDLE, E_RUN, "perf_idle");
        @(negedge clk_i);
        checks++;
        if (bus.stall_cycles_o !== 32'd5) begin
            failures++;
            $display("FAIL stall_cycles: got %0d expected 5", bus.stall_cycles_o);
        end else begin
            $display("ok   stall_cycles: %0d", bus.stall_cycles_o);
        end
        step(1'b1, BR, E_BR, "perf_br_1");
        step(1'b1, BR, E_BR, "perf_br_2");
        step(1'b1, IDLE, E_RUN, "perf_br_idle");
        @(negedge clk_i);
        checks++;
        if (bus.flush_count_o !== 32'd2 || bus.stall_cycles_o !== 32'd5) begin
            failures++;
            $display("FAIL flush_count: got flush=%0d stall=%0d expected flush=2 stall=5",
                     bus.flush_count_o, bus.stall_cycles_o);
        end else begin
            $display("ok   flush_count: %0d", bus.flush_count_o);
        end
`endif

        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk_i input 1 (all state on rising edge), rst_ni input 1 (asynchronous assert, active-low).
REQ-002 Inputs SHALL be:
- load_use_stall_i, 1 -- load-use stall request from the hazard detection unit.
- load_store_forward_sel_i, 1 -- load-to-store forward request for the store currently in ID.
- branch_taken_ex_i, 1 -- branch/jump in EX redirects the PC.
- imem_ready_i, 1 -- instruction fetch response valid this cycle.
- dmem_req_mem_i, 1 -- MEM stage has a data access outstanding.
- dmem_ready_i, 1 -- data memory completes the access this cycle.
REQ-003 Outputs SHALL be:
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o, 1 each -- stage register enables.
- if_id_flush_o, id_ex_flush_o, 1 each -- load a bubble (NOP) into the stage register.
- lsf_sel_ex_o, lsf_sel_mem_o, 1 each -- forward select aligned to EX and MEM.
- stall_cycles_o, 32 -- present only when the perf counter is compiled in (REQ-018).
- flush_count_o, 32 -- present only when the perf counter is compiled in (REQ-018).

Function
REQ-004 The state machine SHALL have the states RUN, LOAD_STALL, MEM_WAIT and FETCH_KILL.
REQ-005 Priority SHALL be, highest first: dmem freeze, then branch flush, then load-use stall, then fetch stall.
REQ-006 Dmem freeze applies when dmem_req_mem_i=1 and dmem_ready_i=0: all five enables 0, no flush asserted, next state MEM_WAIT; MEM_WAIT exits to RUN in the cycle dmem_ready_i=1, and all enables are 1 that cycle.
REQ-007 Branch flush applies when branch_taken_ex_i=1 and there is no freeze:
- pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1, all other enables 1.
- A simultaneous load_use_stall_i SHALL be ignored.
REQ-008 A branch flush while imem_ready_i=0 SHALL set kill_pending and enter FETCH_KILL.
- In FETCH_KILL, the first cycle with imem_ready_i=1 SHALL assert if_id_flush_o to discard the wrong-path response, clear kill_pending, and return to RUN.
REQ-009 Load-use stall applies when load_use_stall_i=1 and there is no freeze or flush:
- pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, EX/MEM/WB enables 1.
- Enter LOAD_STALL for exactly one cycle, then RUN.
REQ-010 A load_use_stall_i still high in LOAD_STALL SHALL stall again (no deadlock, no skip).
REQ-011 Fetch stall applies when imem_ready_i=0 in RUN with no other condition: pc_en_o=0, if_id_flush_o=1, downstream enables 1.
REQ-012 lsf_sel_ex_o SHALL register load_store_forward_sel_i when id_ex_en_o=1 and clear when id_ex_flush_o=1.
REQ-013 lsf_sel_mem_o SHALL register lsf_sel_ex_o when ex_mem_en_o=1; both registers hold during freeze.
REQ-014 Load_store_forward_sel_i=1 together with load_use_stall_i=0 SHALL NOT stall.
REQ-015 All enable/flush outputs SHALL be combinational from state and inputs, with a latency of 0 cycles.

Reset
REQ-016 While rst_ni=0: all enables 0, both flushes 1, state RUN, kill_pending 0, lsf registers 0, counters 0.
REQ-017 Reset asserted mid-stall or mid-kill SHALL abandon the operation with no residual flush after release; the first cycle after release is RUN.

Configuration
REQ-018 With STALL_PERF_CNT_EN defined:
- stall_cycles_o increments on every cycle with pc_en_o=0 outside reset.
- flush_count_o increments per branch flush.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-019 Without STALL_PERF_CNT_EN, both ports and the counter logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-020 The state enum (2-bit) and NOP-bubble encoding constants SHALL reside in the shared core package.
REQ-021 The counters SHALL be one sub-module, stall_perf_counter, instantiated twice under STALL_PERF_CNT_EN.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Load-use stall: load_use_stall_i=1 for 1 cycle -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1 for exactly 1 cycle, then all enables 1.
- Freeze plus branch: dmem_req_mem_i=1, dmem_ready_i=0 for 3 cycles with branch_taken_ex_i=1 -> all enables 0 for 3 cycles, no flush; on ready, a single flush cycle.
- Branch plus load-use: branch_taken_ex_i=1 and load_use_stall_i=1 together -> flush of IF/ID and ID/EX, pc_en_o=1, no stall.
- Fetch kill: branch while imem_ready_i=0, ready returns 2 cycles later -> if_id_flush_o=1 on that return cycle only.
- Forward alignment: load_store_forward_sel_i=1 -> lsf_sel_ex_o=1 next cycle, lsf_sel_mem_o=1 the cycle after; with STALL_PERF_CNT_EN, 5 stall cycles -> stall_cycles_o=5.
